// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives requests and operands; the slave returns results and status.
interface seq_signed_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, dz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, dz
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit
// per clock, then sign correction. Truncates toward zero; remainder follows dividend.
module seq_signed_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH:0]   mag_b_reg;
    logic [WIDTH-1:0] a_orig_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dz_reg;
    logic             done_reg;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        // W-bit negate of the most negative value wraps to itself, which reads
        // correctly as the unsigned magnitude 2^(W-1).
        abs_a   = bus.a[WIDTH-1] ? (WIDTH'(0) - bus.a) : bus.a;
        b_ext   = {bus.b[WIDTH-1], bus.b};
        abs_b   = bus.b[WIDTH-1] ? ((WIDTH+1)'(0) - b_ext) : b_ext;
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        trial   = shifted - {1'b0, mag_b_reg};
        q_fix   = sign_q_reg ? (WIDTH'(0) - quo_reg) : quo_reg;
        r_fix   = sign_r_reg ? (WIDTH'(0) - rem_reg[WIDTH-1:0]) : rem_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            mag_b_reg  <= '0;
            a_orig_reg <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            zero_reg   <= 1'b0;
            q_reg      <= '0;
            r_reg      <= '0;
            dz_reg     <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mag_b_reg  <= abs_b;
                        a_orig_reg <= bus.a;
                        sign_q_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        sign_r_reg <= bus.a[WIDTH-1];
                        zero_reg   <= (bus.b == '0);
                        rem_reg    <= '0;
                        quo_reg    <= abs_a;
                        cnt_reg    <= CW'(WIDTH);
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    // Restoring step: keep the trial difference only if it did not borrow.
                    if (!trial[WIDTH+1]) begin
                        rem_reg <= trial[WIDTH:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[WIDTH:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (zero_reg) begin
                        q_reg  <= '1;
                        r_reg  <= a_orig_reg;
                        dz_reg <= 1'b1;
                    end else begin
                        q_reg  <= q_fix;
                        r_reg  <= r_fix;
                        dz_reg <= 1'b0;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.dz   = dz_reg;
    assign bus.done = done_reg;
    assign bus.busy = (state_reg != IDLE);
endmodule
